btn_irq_debouncer: RTL and testbench

- Parametrised N-channel front end for board push-buttons and switches feeding the SoC interrupt and GPIO inputs.
- Synchronises each raw pad to clk_i, debounces it with a per-channel counter, and detects edges under a per-channel runtime mode.
- Holds a sticky IRQ pending bit per channel until acknowledged.
- Generalises direct button-to-IRQ wiring: arbitrary channel count, configurable filter length, selectable edge polarity, pending/ack handshake.

---
 rtl/btn_irq_debouncer.sv | 98 +++++++++
 tb/tb_btn_irq_debouncer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_debouncer.sv
// Push-button / switch front end: per-channel synchroniser, debounce filter,
// accepted-edge pulse and sticky interrupt pending bit with acknowledge.
module btn_irq_debouncer #(
  parameter int NCH             = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NCH-1:0]   btn_i,
  input  logic [2*NCH-1:0] mode_i,
  input  logic [NCH-1:0]   irq_ack_i,
  output logic [NCH-1:0]   level_o,
  output logic [NCH-1:0]   edge_o,
  output logic [NCH-1:0]   irq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // new_level is the level just accepted, i.e. the value level_o shows while edge_o is high
  function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
    logic q;
    case (mode)
      MODE_OFF:  q = 1'b0;
      MODE_RISE: q = new_level;
      MODE_FALL: q = ~new_level;
      MODE_BOTH: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [SYNC_STAGES-1:0] sync_d [NCH];
  logic [CNT_W-1:0]       cnt_q  [NCH];
  logic [CNT_W-1:0]       cnt_d  [NCH];
  logic [NCH-1:0]         level_q, level_d;
  logic [NCH-1:0]         edge_q, edge_d;
  logic [NCH-1:0]         irq_q, irq_d;
  logic [NCH-1:0]         sync_s;
  logic [NCH-1:0]         qualify_s;

  // Next-state: synchroniser shift, debounce count/accept, pending update
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sync_d[k]    = {sync_q[k][SYNC_STAGES-2:0], btn_i[k]};
      sync_s[k]    = sync_q[k][SYNC_STAGES-1];
      cnt_d[k]     = '0;
      level_d[k]   = level_q[k];
      edge_d[k]    = 1'b0;
      qualify_s[k] = edge_q[k] & edge_qualifies(mode_i[2*k +: 2], level_q[k]);
      // set has priority so an ack racing a fresh event never loses it
      irq_d[k]     = qualify_s[k] | (irq_q[k] & ~irq_ack_i[k]);

      if (sync_s[k] == level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] >= CNT_LAST) begin
        level_d[k] = sync_s[k];
        edge_d[k]  = 1'b1;
        cnt_d[k]   = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NCH; k++) begin
        sync_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      level_q <= '0;
      edge_q  <= '0;
      irq_q   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        sync_q[k] <= sync_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      level_q <= level_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_btn_irq_debouncer.sv
// Bench for btn_irq_debouncer: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a run-length model.
module tb_btn_irq_debouncer;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DC  = 8;
  localparam int CW  = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   btn   = '0;
  logic [NCH-1:0]   ack   = '0;
  logic [2*NCH-1:0] mode  = '0;
  logic [NCH-1:0]   level_o, edge_o, irq_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [NCH-1:0] m_level = '0;
  logic [NCH-1:0] m_edge  = '0;
  logic [NCH-1:0] m_irq   = '0;
  int             run    [NCH];
  int             epulse [NCH];
  logic [NCH-1:0] pipe   [$];

  always #5 clk = ~clk;

  btn_irq_debouncer #(
    .NCH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .btn_i(btn), .mode_i(mode),
    .irq_ack_i(ack), .level_o(level_o), .edge_o(edge_o), .irq_o(irq_o)
  );

  task automatic check(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) epulse[k] += int'(edge_o[k]);
    end
  endtask

  // Model: the pad value seen by the filter is the one sampled SS edges earlier;
  // a level is accepted after DC consecutive disagreeing samples.
  initial begin : model
    logic [NCH-1:0] used, nedge;
    logic [1:0]     md;
    logic           qual;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pipe.delete();
        for (int i = 0; i < SS; i++) pipe.push_back('0);
        m_level = '0;
        m_edge  = '0;
        m_irq   = '0;
        for (int k = 0; k < NCH; k++) run[k] = 0;
      end else begin
        used = pipe.pop_front();
        pipe.push_back(btn);
        nedge = '0;
        for (int k = 0; k < NCH; k++) begin
          md   = mode[2*k +: 2];
          qual = m_edge[k] && ((md == 2'b11) || (md == 2'b01 && m_level[k]) ||
                               (md == 2'b10 && !m_level[k]));
          m_irq[k] = qual | (m_irq[k] & ~ack[k]);
          if (used[k] !== m_level[k]) begin
            run[k]++;
            if (run[k] == DC) begin
              m_level[k] = used[k];
              nedge[k]   = 1'b1;
              run[k]     = 0;
            end
          end else begin
            run[k] = 0;
          end
        end
        m_edge = nedge;
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_level", level_o, m_level);
        check("model_edge",  edge_o,  m_edge);
        check("model_irq",   irq_o,   m_irq);
      end
    end
  end

  initial begin : stim
    bit found;
    for (int k = 0; k < NCH; k++) epulse[k] = 0;

    // 1. reset and latency
    mode = 8'b11_10_11_01;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_level", level_o, 4'b0000);
    check("rst_edge",  edge_o,  4'b0000);
    check("rst_irq",   irq_o,   4'b0000);
    rst_n  = 1'b1;
    btn[0] = 1'b1;
    tick(9);
    check("t1_level_e9", level_o & 4'b0001, 4'b0000);
    tick(1);
    check("t1_level_e10", level_o & 4'b0001, 4'b0001);
    check("t1_edge_e10",  edge_o  & 4'b0001, 4'b0001);
    tick(1);
    check("t1_edge_e11", edge_o & 4'b0001, 4'b0000);
    check("t1_irq",      irq_o  & 4'b0001, 4'b0001);

    // 2. glitch rejection on ch1
    btn[1] = 1'b1; tick(7);
    btn[1] = 1'b0; tick(3);
    btn[1] = 1'b1; tick(7);
    btn[1] = 1'b0; tick(15);
    check("t2_level", level_o & 4'b0010, 4'b0000);
    check("t2_irq",   irq_o   & 4'b0010, 4'b0000);

    // 3. mode filtering on ch2: falling only, then off
    epulse[2] = 0;
    btn[2] = 1'b1; tick(20);
    check("t3_press_level", level_o & 4'b0100, 4'b0100);
    check("t3_press_irq",   irq_o   & 4'b0100, 4'b0000);
    btn[2] = 1'b0; tick(20);
    check("t3_rel_level", level_o & 4'b0100, 4'b0000);
    check("t3_rel_irq",   irq_o   & 4'b0100, 4'b0100);
    check_int("t3_pulses", epulse[2], 2);
    ack = 4'b0100; tick(1); ack = '0;
    mode[5:4] = 2'b00;
    epulse[2] = 0;
    btn[2] = 1'b1; tick(20);
    check("t3_off_level", level_o & 4'b0100, 4'b0100);
    btn[2] = 1'b0; tick(20);
    check("t3_off_irq", irq_o & 4'b0100, 4'b0000);
    check_int("t3_off_pulses", epulse[2], 2);

    // 4. ack racing a new edge on ch3 (mode 11)
    btn[3] = 1'b1; tick(20);
    check("t4_pending", irq_o & 4'b1000, 4'b1000);
    btn[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (edge_o[3]) found = 1'b1;
    end
    check_int("t4_edge_seen", int'(found), 1);
    ack[3] = 1'b1; tick(1); ack[3] = 1'b0;
    check("t4_race_irq", irq_o & 4'b1000, 4'b1000);
    tick(3);
    ack[3] = 1'b1; tick(1); ack[3] = 1'b0;
    check("t4_ack_irq", irq_o & 4'b1000, 4'b0000);

    // 5. reset mid-debounce discards the count
    btn[0] = 1'b0; tick(20);
    btn[0] = 1'b1; tick(7);
    rst_n = 1'b0; tick(1);
    check("t5_rst_level", level_o, 4'b0000);
    check("t5_rst_irq",   irq_o,   4'b0000);
    rst_n = 1'b1;
    tick(9);
    check("t5_level_e9", level_o & 4'b0001, 4'b0000);
    tick(1);
    check("t5_level_e10", level_o & 4'b0001, 4'b0001);

    // 6. all channels at once
    mode = 8'hFF;
    btn  = '0; tick(20);
    ack  = 4'hF; tick(1); ack = '0;
    check("t6_cleared", irq_o, 4'b0000);
    btn = 4'hF;
    tick(9);
    check("t6_edge_e9", edge_o, 4'b0000);
    tick(1);
    check("t6_edge_e10",  edge_o,  4'b1111);
    check("t6_level_e10", level_o, 4'b1111);
    tick(1);
    check("t6_irq_all", irq_o, 4'b1111);
    ack = 4'b0100; tick(1); ack = '0;
    check("t6_irq_ack2", irq_o, 4'b1011);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 11) == 0) btn[k] = ~btn[k];
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      ack   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
